rr_arb4_ctrl: RTL and testbench

Four-agent round-robin arbiter that shares a single downstream resource between requesters `req_0`..`req_3`. It replaces fixed-priority granting with rotating priority, an idle cycle between owners, and optional hold-time preemption so no agent can starve the others. It sits between the requesting agents and the shared resource's enable, and drives one-hot registered grants.

---
 rtl/rr_arb4_ctrl.sv | 154 +++++++++++++++
 tb/tb_rr_arb4_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: four-agent round-robin arbiter with registered one-hot grants
// and an enforced idle cycle between owners.
// Optional hold-time preemption is compiled in when ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no grant; scan requests starting after the last owner
// GRANT  | agent own_q holds the resource until it drops req (or is preempted)
module rr_arb4_ctrl #(
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  input  logic req_2,
  input  logic req_3,
  output logic gnt_0,
  output logic gnt_1,
  output logic gnt_2,
  output logic gnt_3,
  output logic busy,
  output logic preempt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  own_q, own_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic        preempt_q, preempt_d;

  logic [3:0]  req_v;
  logic [1:0]  sel;
  logic        sel_found;
  logic        others_req;

  assign req_v = {req_3, req_2, req_1, req_0};

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_max;
  assign hold_max = (hold_cnt_q == HOLD_W'(MAX_HOLD));
`else
  logic [HOLD_W-1:0] unused_max_hold;
  assign unused_max_hold = HOLD_W'(MAX_HOLD);
`endif

  // Rotating-priority scan: own+1, own+2, own+3, then own itself.
  always_comb begin
    logic [1:0] idx;
    sel       = own_q;
    sel_found = 1'b0;
    idx       = own_q;
    for (int i = 1; i <= 4; i++) begin
      idx = own_q + 2'(i);
      if (!sel_found && req_v[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Any requester other than the current owner (used only for preemption).
  assign others_req = |(req_v & ~(4'b0001 << own_q));

  // Next-state and next-output decode; outputs default low so every exit
  // from GRANT (and any illegal encoding) produces the all-low gap cycle.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    gnt_d     = 4'b0000;
    busy_d    = 1'b0;
    preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          own_d   = sel;
          gnt_d   = 4'b0001 << sel;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = HOLD_W'(1);
`endif
        end
      end
      ST_GRANT: begin
        if (!req_v[own_q]) begin
          // Normal release wins over a simultaneous preemption condition.
          state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_max && others_req) begin
          preempt_d = 1'b1;
          state_d   = ST_IDLE;
`endif
        end else begin
          gnt_d  = 4'b0001 << own_q;
          busy_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          if (!hold_max) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifndef ARB_TIMEOUT_EN
    if (others_req && 1'b0) preempt_d = 1'b0;
`endif
  end

  // State, owner pointer and registered outputs; reset points own at 3 so
  // agent 0 is scanned first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      own_q     <= 2'd3;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Consecutive granted-cycle counter, saturating at MAX_HOLD.
  always_ff @(posedge clock) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`endif

  assign gnt_0   = gnt_q[0];
  assign gnt_1   = gnt_q[1];
  assign gnt_2   = gnt_q[2];
  assign gnt_3   = gnt_q[3];
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Testbench for rr_arb4_ctrl (MAX_HOLD=4). Expected outputs for each cycle
// are pushed onto a scoreboard queue as stimulus is driven and popped after
// the clock edge. Expectations follow ARB_TIMEOUT_EN when it is defined.
module tb_rr_arb4_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_0 = 1'b0, req_1 = 1'b0, req_2 = 1'b0, req_3 = 1'b0;
  logic gnt_0, gnt_1, gnt_2, gnt_3, busy, preempt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [5:0] exp;
  } stim_t;

  logic [5:0] sb_q[$];

  rr_arb4_ctrl #(.HOLD_W(4), .MAX_HOLD(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .req_0  (req_0),
    .req_1  (req_1),
    .req_2  (req_2),
    .req_3  (req_3),
    .gnt_0  (gnt_0),
    .gnt_1  (gnt_1),
    .gnt_2  (gnt_2),
    .gnt_3  (gnt_3),
    .busy   (busy),
    .preempt(preempt)
  );

  always #5 clock = ~clock;

  // Expected {gnt_3..gnt_0, busy, preempt}: g<0 means no grant.
  function automatic logic [5:0] ex(int g, logic p);
    logic [3:0] one;
    if (g < 0) return {4'b0000, 1'b0, p};
    one = 4'b0001 << g;
    return {one, 1'b1, 1'b0};
  endfunction

  function automatic stim_t st(logic r, logic [3:0] q, logic [5:0] e);
    stim_t s;
    s.rst = r; s.req = q; s.exp = e;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst;
    {req_3, req_2, req_1, req_0} = s.req;
    sb_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    stim_t v[$];
    logic [5:0] obs, e;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    v.push_back(st(0, 4'hF, ex(0, 0)));
    v.push_back(st(0, 4'h0, ex(-1, 0)));
    v.push_back(st(0, 4'h0, ex(-1, 0)));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL reset[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_rotation();
    stim_t v[$];
    logic [5:0] obs, e;
    logic [3:0] drop;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    for (int a = 0; a < 4; a++) begin
      drop = 4'hF & ~(4'b0001 << a);
      v.push_back(st(0, 4'hF, ex(a, 0)));
      v.push_back(st(0, 4'hF, ex(a, 0)));
      v.push_back(st(0, 4'hF, ex(a, 0)));
      v.push_back(st(0, drop, ex(-1, 0)));
    end
    v.push_back(st(0, 4'hF, ex(0, 0)));
    v.push_back(st(0, 4'h0, ex(-1, 0)));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL rotation[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_preempt();
    stim_t v[$];
    logic [5:0] obs, e;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    v.push_back(st(0, 4'b0100, ex(2, 0)));
    v.push_back(st(0, 4'b0100, ex(2, 0)));
    v.push_back(st(0, 4'b0110, ex(2, 0)));
    v.push_back(st(0, 4'b0110, ex(2, 0)));
`ifdef ARB_TIMEOUT_EN
    v.push_back(st(0, 4'b0110, ex(-1, 1)));
    v.push_back(st(0, 4'b0110, ex(1, 0)));
    v.push_back(st(0, 4'b0100, ex(-1, 0)));
`else
    for (int k = 0; k < 4; k++) v.push_back(st(0, 4'b0110, ex(2, 0)));
    v.push_back(st(0, 4'b0010, ex(-1, 0)));
    v.push_back(st(0, 4'b0010, ex(1, 0)));
    v.push_back(st(0, 4'b0000, ex(-1, 0)));
`endif
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL preempt[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_sole_requester();
    stim_t v[$];
    logic [5:0] obs, e;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    for (int k = 0; k < 20; k++) v.push_back(st(0, 4'b1000, ex(3, 0)));
`ifdef ARB_TIMEOUT_EN
    v.push_back(st(0, 4'b1001, ex(-1, 1)));
    v.push_back(st(0, 4'b1001, ex(0, 0)));
`else
    v.push_back(st(0, 4'b1001, ex(3, 0)));
    v.push_back(st(0, 4'b0001, ex(-1, 0)));
    v.push_back(st(0, 4'b0001, ex(0, 0)));
`endif
    v.push_back(st(0, 4'b0000, ex(-1, 0)));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL sole[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_release_vs_preempt();
    stim_t v[$];
    logic [5:0] obs, e;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    v.push_back(st(0, 4'b0010, ex(1, 0)));
    v.push_back(st(0, 4'b0011, ex(1, 0)));
    v.push_back(st(0, 4'b0011, ex(1, 0)));
    v.push_back(st(0, 4'b0011, ex(1, 0)));
    v.push_back(st(0, 4'b0001, ex(-1, 0)));
    v.push_back(st(0, 4'b0001, ex(0, 0)));
    v.push_back(st(0, 4'b0000, ex(-1, 0)));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL release_vs_preempt[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_grant();
    stim_t v[$];
    logic [5:0] obs, e;
    v.push_back(st(1, 4'h0, ex(-1, 0)));
    v.push_back(st(0, 4'b0100, ex(2, 0)));
    v.push_back(st(0, 4'b0100, ex(2, 0)));
    v.push_back(st(1, 4'b0100, ex(-1, 0)));
    v.push_back(st(0, 4'hF, ex(0, 0)));
    v.push_back(st(0, 4'hE, ex(-1, 0)));
    v.push_back(st(0, 4'hE, ex(1, 0)));
    v.push_back(st(0, 4'h0, ex(-1, 0)));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clock); #1;
      obs = {gnt_3, gnt_2, gnt_1, gnt_0, busy, preempt};
      e = sb_q.pop_front();
      total_cnt++;
      if (obs !== e) $display("FAIL reset_mid_grant[%0d]: got {gnt3..0,busy,pre}=%b want %b", i, obs, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_preempt();
    test_sole_requester();
    test_release_vs_preempt();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
